mem_stage: RTL
==============

Name: mem_stage

Overview:
- Pipeline memory stage, directly downstream of the execute stage.
- Owns the EX/MEM latch, drives the datapath-side data-cache request, and stalls the pipeline until dhit.
- Selects writeback data and registers it into the MEM/WB latch for the writeback/register-file stage.

Parameters:
WORD_W, 32, datapath word width
REG_W, 5, register-file address width

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction fetch hit; global advance enable
flush  in  1  kill incoming EX result (captured as bubble)
ex_aluout  in  WORD_W  ALU result; data address for loads/stores
ex_rtdat  in  WORD_W  store data
ex_npc  in  WORD_W  PC+4 for link writes
ex_dren  in  1  load
ex_dwen  in  1  store
ex_datomic  in  1  LL/SC qualifier
ex_regwr  in  1  register write enable
ex_regsel  in  2  writeback select: 0 ALU, 1 load data, 2 nPC, 3 ALU
ex_regdst  in  REG_W  destination register
dhit  in  1  data cache request complete
dmemload  in  WORD_W  load data, valid with dhit
dmemREN  out  1  data read request
dmemWEN  out  1  data write request
datomic  out  1  atomic qualifier to cache
dmemaddr  out  WORD_W  data address
dmemstore  out  WORD_W  store data
mem_stall  out  1  stage busy; freezes all upstream latches
wb_regwr  out  1  MEM/WB register write enable
wb_regdst  out  REG_W  MEM/WB destination
wb_wdat  out  WORD_W  MEM/WB write data

Behaviour:
- All resets are asynchronous on nRST low:
  - latch contents, state=IDLE, HOLD buffer, link register → 0;
  - wb_regwr=0, wb_regdst=0, wb_wdat=0;
  - dmemREN=dmemWEN=datomic=0.
- advance = ihit & ~mem_stall. On advance:
  - EX/MEM latch captures ex_* inputs;
  - if flush=1, it captures a bubble instead (all enables 0, regdst 0).
- Latched op classification:
  - op_st = dwen;
  - op_ld = dren & ~dwen (dwen has priority when both are set);
  - mem_op = op_ld | op_st.
- State machine, IDLE / ACCESS / HOLD:
  - After an advance, next state = ACCESS if the captured op is a mem_op, else IDLE.
  - ACCESS:
    - dmemREN=op_ld, dmemWEN=op_st;
    - dmemaddr=latched aluout, dmemstore=latched rtdat;
    - requests are held stable until dhit.
  - ACCESS & dhit & ~ihit → HOLD: dmemload captured into the HOLD buffer; requests drop the same cycle.
  - ACCESS & dhit & ihit → advance directly in that cycle; dmemload is used as the load data.
  - HOLD: no requests; waits for ihit, then advances.
  - IDLE: no requests.
- mem_stall = (state==ACCESS) & ~dhit. Combinational; asserted the first cycle of ACCESS.
- Writeback data, registered into MEM/WB on advance:
  - regsel 0/3 → aluout;
  - regsel 1 → load data (dmemload in ACCESS, HOLD buffer in HOLD);
  - regsel 2 → npc.
- MEM/WB hold rules:
  - MEM/WB holds its value when advance=0.
  - wb_regwr is cleared on an advance that carries a bubble.
- Latency: non-memory op reaches MEM/WB 1 advance after capture; loads complete no earlier than the dhit cycle.
- flush never cancels an in-flight ACCESS. The latched op is older than the flushing branch and completes normally.
- nRST low mid-ACCESS: request deasserts immediately; the op is discarded.

Optional Feature:
Macro LLSC_EN.
- Defined:
  - One-entry link register {valid, addr}.
  - Completed LL (op_ld & datomic) sets valid=1, addr=dmemaddr.
  - SC (op_st & datomic):
    - valid & addr match → store issued, wb_wdat=1, valid cleared;
    - otherwise → no request, no stall (state IDLE after capture), wb_wdat=0.
  - SC writeback data is forced to 1/0, overriding regsel.
  - Any completed plain store to the linked addr clears valid.
  - datomic output = latched datomic during ACCESS.
- Undefined: datomic output tied 0; ex_datomic ignored; LL/SC behave as plain load/store.

Test Plan:
- Reset mid-ACCESS: nRST low while dmemREN=1 → dmemREN=0, wb_* all 0, mem_stall=0 immediately.
- ALU op add → aluout=0x0000_0010, regsel 0, regdst 5, ihit=1 → next cycle wb_wdat=0x10, wb_regdst=5, wb_regwr=1, no request.
- Load addr 0x100, dhit after 3 cycles with dmemload=0xDEADBEEF, ihit=1 → mem_stall high 3 cycles; dmemREN stable; wb_wdat=0xDEADBEEF the next cycle.
- Load dhit while ihit=0 for 2 cycles, then ihit=1 → state HOLD, dmemREN=0, mem_stall=0; wb_wdat=HOLD buffer value after ihit.
- Store with ex_dren=ex_dwen=1 plus flush asserted during ACCESS → only dmemWEN=1, addr and data stable; store completes; next capture is a bubble (wb_regwr=0).
- LLSC_EN: LL 0x200 then SC 0x200 → dmemWEN pulse, wb_wdat=1. Repeat SC 0x200 → no request, no stall, wb_wdat=0.

Source files
------------

// File: rtl/mem_stage.sv
// Pipeline memory stage: EX/MEM latch, data-cache request sequencing, MEM/WB latch.
// Define LLSC_EN to enable the one-entry link register for LL/SC.
module mem_stage #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              flush,
    input  logic [WORD_W-1:0] ex_aluout,
    input  logic [WORD_W-1:0] ex_rtdat,
    input  logic [WORD_W-1:0] ex_npc,
    input  logic              ex_dren,
    input  logic              ex_dwen,
    input  logic              ex_datomic,
    input  logic              ex_regwr,
    input  logic [1:0]        ex_regsel,
    input  logic [REG_W-1:0]  ex_regdst,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic              datomic,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic              wb_regwr,
    output logic [REG_W-1:0]  wb_regdst,
    output logic [WORD_W-1:0] wb_wdat
);

`ifdef LLSC_EN
    localparam bit LLSC = 1'b1;
`else
    localparam bit LLSC = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   aluout_q, aluout_d, rtdat_q, rtdat_d, npc_q, npc_d;
    logic                dren_q, dren_d, dwen_q, dwen_d, datomic_q, datomic_d;
    logic                regwr_q, regwr_d, sc_fail_q, sc_fail_d;
    logic [1:0]          regsel_q, regsel_d;
    logic [REG_W-1:0]    regdst_q, regdst_d;
    logic [WORD_W-1:0]   hold_q, hold_d;
    logic                link_valid_q, link_valid_d;
    logic [WORD_W-1:0]   link_addr_q, link_addr_d;
    logic                wb_regwr_q, wb_regwr_d;
    logic [REG_W-1:0]    wb_regdst_q, wb_regdst_d;
    logic [WORD_W-1:0]   wb_wdat_q, wb_wdat_d;

    logic              advance, op_ld, op_st, in_access, done, sc_fail_new, cap_mem;
    logic [WORD_W-1:0] ld_data, wdat_sel;

    always_comb begin
        in_access = (state_q == ACCESS);
        op_st     = dwen_q;
        op_ld     = dren_q & ~dwen_q;
        mem_stall = in_access & ~dhit;
        advance   = ihit & ~mem_stall;
        done      = in_access & dhit;

        dmemREN   = in_access & op_ld;
        dmemWEN   = in_access & op_st;
        datomic   = in_access & datomic_q;
        dmemaddr  = aluout_q;
        dmemstore = rtdat_q;

        ld_data = (state_q == HOLD) ? hold_q : dmemload;
        case (regsel_q)
            2'd1:    wdat_sel = ld_data;
            2'd2:    wdat_sel = npc_q;
            default: wdat_sel = aluout_q;
        endcase
        if (op_st & datomic_q)
            wdat_sel = {{(WORD_W-1){1'b0}}, ~sc_fail_q};
    end

    // Link register is updated when the access completes, so an SC captured on the
    // same edge as its LL's completion sees the new link via the _d values.
    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (done) begin
            if (op_ld & datomic_q) begin
                link_valid_d = 1'b1;
                link_addr_d  = aluout_q;
            end else if (op_st & (datomic_q | (aluout_q == link_addr_q))) begin
                link_valid_d = 1'b0;
            end
        end
        sc_fail_new = LLSC & ex_dwen & ex_datomic
                      & ~(link_valid_d & (link_addr_d == ex_aluout));
        cap_mem     = ~flush & (ex_dren | ex_dwen) & ~sc_fail_new;
    end

    always_comb begin
        aluout_d  = aluout_q;
        rtdat_d   = rtdat_q;
        npc_d     = npc_q;
        dren_d    = dren_q;
        dwen_d    = dwen_q;
        datomic_d = datomic_q;
        regwr_d   = regwr_q;
        sc_fail_d = sc_fail_q;
        regsel_d  = regsel_q;
        regdst_d  = regdst_q;
        hold_d    = hold_q;
        state_d   = state_q;
        wb_regwr_d  = wb_regwr_q;
        wb_regdst_d = wb_regdst_q;
        wb_wdat_d   = wb_wdat_q;

        if (done & ~ihit)
            hold_d = dmemload;

        if (advance) begin
            wb_regwr_d  = regwr_q;
            wb_regdst_d = regdst_q;
            wb_wdat_d   = wdat_sel;
            state_d     = cap_mem ? ACCESS : IDLE;
            if (flush) begin
                aluout_d  = '0;
                rtdat_d   = '0;
                npc_d     = '0;
                dren_d    = 1'b0;
                dwen_d    = 1'b0;
                datomic_d = 1'b0;
                regwr_d   = 1'b0;
                sc_fail_d = 1'b0;
                regsel_d  = 2'd0;
                regdst_d  = '0;
            end else begin
                aluout_d  = ex_aluout;
                rtdat_d   = ex_rtdat;
                npc_d     = ex_npc;
                dren_d    = ex_dren;
                dwen_d    = ex_dwen;
                datomic_d = ex_datomic & LLSC;
                regwr_d   = ex_regwr;
                sc_fail_d = sc_fail_new;
                regsel_d  = ex_regsel;
                regdst_d  = ex_regdst;
            end
        end else if (done) begin
            state_d = HOLD;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            aluout_q     <= '0;
            rtdat_q      <= '0;
            npc_q        <= '0;
            dren_q       <= 1'b0;
            dwen_q       <= 1'b0;
            datomic_q    <= 1'b0;
            regwr_q      <= 1'b0;
            sc_fail_q    <= 1'b0;
            regsel_q     <= 2'd0;
            regdst_q     <= '0;
            hold_q       <= '0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
            wb_regwr_q   <= 1'b0;
            wb_regdst_q  <= '0;
            wb_wdat_q    <= '0;
        end else begin
            state_q      <= state_d;
            aluout_q     <= aluout_d;
            rtdat_q      <= rtdat_d;
            npc_q        <= npc_d;
            dren_q       <= dren_d;
            dwen_q       <= dwen_d;
            datomic_q    <= datomic_d;
            regwr_q      <= regwr_d;
            sc_fail_q    <= sc_fail_d;
            regsel_q     <= regsel_d;
            regdst_q     <= regdst_d;
            hold_q       <= hold_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
            wb_regwr_q   <= wb_regwr_d;
            wb_regdst_q  <= wb_regdst_d;
            wb_wdat_q    <= wb_wdat_d;
        end
    end

    assign wb_regwr  = wb_regwr_q;
    assign wb_regdst = wb_regdst_q;
    assign wb_wdat   = wb_wdat_q;

endmodule
